n64adv_cfg_system: RTL and testbench



---
 rtl/n64adv_cfg_system.sv | 240 ++++++++++++++++++++++++
 tb/tb_n64adv_cfg_system.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64adv_cfg_system.sv
// Hard-wired configuration subsystem for the N64 video mod: holds the two
// configuration words, runs the controller-driven OSD menu once per video
// frame and feeds character writes into the OSD text RAM.
module n64adv_cfg_system #(
  parameter int NITEMS = 8
) (
  input  logic        clk_clk,
  input  logic        rst_reset,
  input  logic [1:0]  sync_in_export,
  input  logic [31:0] ctrl_data_in_export,
  input  logic [7:0]  jumper_cfg_set_in_export,
  input  logic [7:0]  info_set_in_export,
  input  logic [11:0] hdl_fw_in_export,
  output logic [9:0]  vd_wraddr_export,
  output logic [1:0]  vd_wrctrl_export,
  output logic [12:0] vd_wrdata_export,
  output logic [31:0] cfg_set0_out_export,
  output logic [31:0] cfg_set1_out_export
);

  localparam logic [2:0] LAST_ITEM = 3'(NITEMS - 1);

  typedef enum logic [2:0] {W_IDLE, W_INIT, W_MOVE, W_EDIT, W_INFO} wjob_t;

  function automatic logic [6:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (7'h30 + {3'b0, n}) : (7'h37 + {3'b0, n});
  endfunction

  function automatic logic [9:0] line_addr(input logic [2:0] item);
    return {{2'b0, item} + 5'd2, 5'd0};
  endfunction

  function automatic logic [9:0] value_addr(input logic [2:0] item);
    return {{2'b0, item} + 5'd2, 5'd20};
  endfunction

  logic [1:0] s1, s2;
  logic       s2_prev0, fb_prev;
  logic [5:0] cur, prev;          // {R, L, Dr, Dl, Dd, Du}
  logic       proc;
  logic [2:0] cursor, mv_old;
  logic [3:0] info_prev;
  logic       info_pend;
  wjob_t      job, job_nxt;
  logic [3:0] idx, idx_nxt;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [6:0] wr_char;

  logic [3:0] gamma, sl_str;
  logic [1:0] deblur, filter;
  logic       b15, rgsb, ypbpr, line_x2, sl240_en, sl480_en, use_igr, show_osd;

  logic [3:0] info_cur;
  logic       tick, reload, accept;
  logic [5:0] pressed;
  logic       toggle, act_up, act_dn, act_r, act_l, do_edit, move_req;
  logic [31:0] items;
  logic [2:0] item_sel;
  logic       unused_bits;

  assign unused_bits = &{1'b0, jumper_cfg_set_in_export[7], info_set_in_export[7:5],
                         ctrl_data_in_export[31:12], ctrl_data_in_export[9:8],
                         ctrl_data_in_export[3:0]};

  assign info_cur = info_set_in_export[4:1];
  assign tick     = s2[1] & s2[0] & ~s2_prev0;
  assign reload   = info_set_in_export[0] & ~fb_prev;
  assign accept   = tick & (job == W_IDLE) & ~info_pend & ~proc & ~reload;
  assign items    = {3'b0, use_igr, 3'b0, sl480_en, sl_str, 3'b0, sl240_en,
                     2'b0, filter, 3'b0, b15, 2'b0, deblur, gamma};
  assign item_sel = 3'(idx - 4'd4);

  assign cfg_set0_out_export = {4'b0, 1'b0, 1'b1, show_osd, 1'b0, 5'b0, use_igr, 2'b0,
                                1'b0, 3'b0, filter, ypbpr, rgsb, gamma, 1'b0, deblur, b15};
  assign cfg_set1_out_export = {2'b0, line_x2, 5'b0, sl_str, 3'b0, sl240_en,
                                2'b0, line_x2, 5'b0, 4'b0, 3'b0, sl480_en};

  // Two-stage synchronizer on the asynchronous frame/flag inputs
  always_ff @(posedge clk_clk) begin
    s1       <= sync_in_export;
    s2       <= s1;
    s2_prev0 <= s2[0];
  end

  // Button decode: one action per frame, toggle > Du > Dd > Dr > Dl
  always_comb begin
    pressed  = cur & ~prev;
    toggle   = (&{cur[5], cur[4], cur[3]}) & ~(&{prev[5], prev[4], prev[3]});
    act_up   = ~toggle & show_osd & pressed[0];
    act_dn   = ~toggle & show_osd & ~pressed[0] & pressed[1];
    act_r    = ~toggle & show_osd & ~pressed[0] & ~pressed[1] & pressed[3];
    act_l    = ~toggle & show_osd & ~pressed[0] & ~pressed[1] & ~pressed[3] & pressed[2];
    do_edit  = act_r | act_l;
    move_req = (act_up & (cursor != 3'd0)) | (act_dn & (cursor != LAST_ITEM));
  end

  // OSD writer: next job / sequence index and the character to emit
  always_comb begin
    job_nxt = job;
    idx_nxt = idx;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_char = '0;
    if (reload) begin
      job_nxt = W_INIT;
      idx_nxt = '0;
    end else begin
      unique case (job)
        W_IDLE: begin
          idx_nxt = '0;
          if (proc && move_req)       job_nxt = W_MOVE;
          else if (proc && do_edit)   job_nxt = W_EDIT;
          else if (!proc && info_pend) job_nxt = W_INFO;
        end
        W_INIT: begin
          wr_en   = 1'b1;
          idx_nxt = idx + 4'd1;
          case (idx)
            4'd0:    begin wr_addr = 10'd0;  wr_char = hex_char(hdl_fw_in_export[11:8]); end
            4'd1:    begin wr_addr = 10'd1;  wr_char = hex_char(hdl_fw_in_export[7:4]);  end
            4'd2:    begin wr_addr = 10'd2;  wr_char = hex_char(hdl_fw_in_export[3:0]);  end
            4'd3:    begin wr_addr = 10'd4;  wr_char = hex_char(info_cur);               end
            4'd12:   begin wr_addr = 10'd64; wr_char = 7'h3E; job_nxt = W_IDLE;          end
            default: begin
              wr_addr = value_addr(item_sel);
              wr_char = hex_char(items[{item_sel, 2'b00} +: 4]);
            end
          endcase
        end
        W_MOVE: begin
          wr_en   = 1'b1;
          idx_nxt = idx + 4'd1;
          if (idx == 4'd0) begin
            wr_addr = line_addr(mv_old);
            wr_char = 7'h20;
          end else begin
            wr_addr = line_addr(cursor);
            wr_char = 7'h3E;
            job_nxt = W_IDLE;
          end
        end
        W_EDIT: begin
          wr_en   = 1'b1;
          wr_addr = value_addr(cursor);
          wr_char = hex_char(items[{cursor, 2'b00} +: 4]);
          job_nxt = W_IDLE;
        end
        W_INFO: begin
          wr_en   = 1'b1;
          wr_addr = 10'd4;
          wr_char = hex_char(info_cur);
          job_nxt = W_IDLE;
        end
        default: job_nxt = W_IDLE;
      endcase
    end
  end

  // Writer state register and registered RAM write port
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      job              <= W_INIT;
      idx              <= '0;
      vd_wrctrl_export <= 2'b00;
      vd_wraddr_export <= '0;
      vd_wrdata_export <= '0;
    end else begin
      job              <= job_nxt;
      idx              <= idx_nxt;
      vd_wrctrl_export <= {1'b0, wr_en};
      if (wr_en) begin
        vd_wraddr_export <= wr_addr;
        vd_wrdata_export <= {6'b0, wr_char};
      end
    end
  end

  // InfoSet change tracking; a rewrite stays pending until the writer is free
  always_ff @(posedge clk_clk) begin
    info_prev <= info_cur;
    fb_prev   <= info_set_in_export[0];
    if (rst_reset)                                info_pend <= 1'b0;
    else if (info_cur != info_prev)               info_pend <= 1'b1;
    else if (job == W_IDLE && job_nxt == W_INFO)  info_pend <= 1'b0;
  end

  // Frame capture, menu navigation and configuration edits
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      cur  <= '0;
      prev <= '0;
    end
    if (rst_reset || reload) begin
      b15      <= jumper_cfg_set_in_export[0];
      rgsb     <= jumper_cfg_set_in_export[1];
      ypbpr    <= jumper_cfg_set_in_export[2];
      filter   <= jumper_cfg_set_in_export[4:3];
      line_x2  <= jumper_cfg_set_in_export[5];
      sl240_en <= jumper_cfg_set_in_export[6];
      sl480_en <= jumper_cfg_set_in_export[6];
      gamma    <= 4'd5;
      deblur   <= 2'd0;
      sl_str   <= 4'd0;
      use_igr  <= 1'b0;
      show_osd <= 1'b0;
      cursor   <= 3'd0;
      proc     <= 1'b0;
    end else begin
      proc <= 1'b0;
      if (accept) begin
        cur  <= {ctrl_data_in_export[11:10], ctrl_data_in_export[7:4]};
        proc <= 1'b1;
      end
      if (proc) begin
        prev <= cur;
        if (toggle) begin
          show_osd <= ~show_osd;
        end else if (move_req) begin
          mv_old <= cursor;
          cursor <= act_up ? cursor - 3'd1 : cursor + 3'd1;
        end else if (do_edit) begin
          case (cursor)
            3'd0: if (act_r) gamma <= (gamma == 4'd8) ? gamma : gamma + 4'd1;
                  else       gamma <= (gamma == 4'd0) ? gamma : gamma - 4'd1;
            3'd1: deblur <= act_r ? deblur + 2'd1 : deblur - 2'd1;
            3'd2: b15 <= ~b15;
            3'd3: filter <= act_r ? filter + 2'd1 : filter - 2'd1;
            3'd4: sl240_en <= ~sl240_en;
            3'd5: if (act_r) sl_str <= (sl_str == 4'hF) ? sl_str : sl_str + 4'd1;
                  else       sl_str <= (sl_str == 4'h0) ? sl_str : sl_str - 4'd1;
            3'd6: sl480_en <= ~sl480_en;
            default: use_igr <= ~use_igr;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_n64adv_cfg_system.sv
// Self-checking bench for n64adv_cfg_system: a behavioural menu model
// predicts configuration words and queues the expected OSD writes.
module tb_n64adv_cfg_system;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sync_in;
  logic [31:0] ctrl;
  logic [7:0]  jumper, info_set;
  logic [11:0] fw;
  logic [9:0]  wraddr;
  logic [1:0]  wrctrl;
  logic [12:0] wrdata;
  logic [31:0] cfg0, cfg1;

  always #20 clk = ~clk;

  n64adv_cfg_system u_dut (
    .clk_clk                  (clk),
    .rst_reset                (rst),
    .sync_in_export           (sync_in),
    .ctrl_data_in_export      (ctrl),
    .jumper_cfg_set_in_export (jumper),
    .info_set_in_export       (info_set),
    .hdl_fw_in_export         (fw),
    .vd_wraddr_export         (wraddr),
    .vd_wrctrl_export         (wrctrl),
    .vd_wrdata_export         (wrdata),
    .cfg_set0_out_export      (cfg0),
    .cfg_set1_out_export      (cfg1)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Menu model state
  logic [3:0]  m_gamma, m_slstr, m_info;
  logic [1:0]  m_deblur, m_filter;
  logic        m_b15, m_rgsb, m_ypbpr, m_lx2, m_sl240, m_sl480, m_igr, m_osd;
  int          m_cur;
  logic [15:0] m_prev = 16'h0;

  function automatic logic [6:0] hexc(input logic [3:0] n);
    int v;
    v = (n < 10) ? 48 + int'(n) : 55 + int'(n);
    return 7'(v);
  endfunction

  function automatic logic [3:0] item_nib(input int i);
    case (i)
      0: return m_gamma;
      1: return {2'b0, m_deblur};
      2: return {3'b0, m_b15};
      3: return {2'b0, m_filter};
      4: return {3'b0, m_sl240};
      5: return m_slstr;
      6: return {3'b0, m_sl480};
      default: return {3'b0, m_igr};
    endcase
  endfunction

  function automatic logic [31:0] exp_cfg0();
    logic [31:0] v;
    v = 32'h0400_0000;
    v |= 32'(m_osd) << 25;
    v |= 32'(m_igr) << 18;
    v |= 32'(m_filter) << 10;
    v |= 32'(m_ypbpr) << 9;
    v |= 32'(m_rgsb) << 8;
    v |= 32'(m_gamma) << 4;
    v |= 32'(m_deblur) << 1;
    v |= 32'(m_b15);
    return v;
  endfunction

  function automatic logic [31:0] exp_cfg1();
    logic [31:0] v;
    v = (32'(m_lx2) << 29) | (32'(m_slstr) << 20) | (32'(m_sl240) << 16)
      | (32'(m_lx2) << 13) | 32'(m_sl480);
    return v;
  endfunction

  task automatic push_wr(input int addr, input logic [6:0] ch);
    exp_q.push_back({7'b0, 2'b01, 10'(addr), 6'b0, ch});
  endtask

  task automatic load_defaults();
    m_b15 = jumper[0]; m_rgsb = jumper[1]; m_ypbpr = jumper[2]; m_filter = jumper[4:3];
    m_lx2 = jumper[5]; m_sl240 = jumper[6]; m_sl480 = jumper[6];
    m_gamma = 4'd5; m_deblur = 2'd0; m_slstr = 4'd0; m_igr = 1'b0; m_osd = 1'b0;
    m_cur = 0;
    push_wr(0, hexc(fw[11:8]));
    push_wr(1, hexc(fw[7:4]));
    push_wr(2, hexc(fw[3:0]));
    push_wr(4, hexc(m_info));
    for (int i = 0; i < 8; i++) push_wr((i + 2) * 32 + 20, hexc(item_nib(i)));
    push_wr(64, 7'h3E);
  endtask

  task automatic edit_item(input int i, input logic r);
    case (i)
      0: if (r) begin if (m_gamma < 8) m_gamma++; end else begin if (m_gamma > 0) m_gamma--; end
      1: m_deblur = m_deblur + (r ? 2'd1 : 2'd3);
      2: m_b15 = ~m_b15;
      3: m_filter = m_filter + (r ? 2'd1 : 2'd3);
      4: m_sl240 = ~m_sl240;
      5: if (r) begin if (m_slstr < 15) m_slstr++; end else begin if (m_slstr > 0) m_slstr--; end
      6: m_sl480 = ~m_sl480;
      default: m_igr = ~m_igr;
    endcase
  endtask

  // Every write the DUT issues is matched against the scoreboard head
  always @(negedge clk) begin
    if (!rst && wrctrl != 2'b00) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check_val("osd_write", {7'b0, wrctrl, wraddr, wrdata}, mon_exp);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic check_cfg(input string tag);
    @(negedge clk);
    check_val({tag, "_cfg0"}, cfg0, exp_cfg0());
    check_val({tag, "_cfg1"}, cfg1, exp_cfg1());
  endtask

  task automatic frame(input logic flag, input logic [15:0] w);
    ctrl = {16'hA5C3, w};
    sync_in = {flag, 1'b0};
    repeat (4) @(posedge clk);
    sync_in = {flag, 1'b1};
    repeat (4) @(posedge clk);
    drain();
  endtask

  task automatic press(input logic [15:0] w);
    logic [15:0] pr;
    logic tog;
    pr  = w & ~m_prev;
    tog = (w[10] & w[11] & w[7]) & ~(m_prev[10] & m_prev[11] & m_prev[7]);
    if (tog) begin
      m_osd = ~m_osd;
    end else if (m_osd) begin
      if (pr[4]) begin
        if (m_cur > 0) begin
          push_wr((m_cur + 2) * 32, 7'h20);
          m_cur--;
          push_wr((m_cur + 2) * 32, 7'h3E);
        end
      end else if (pr[5]) begin
        if (m_cur < 7) begin
          push_wr((m_cur + 2) * 32, 7'h20);
          m_cur++;
          push_wr((m_cur + 2) * 32, 7'h3E);
        end
      end else if (pr[7] || pr[6]) begin
        edit_item(m_cur, pr[7]);
        push_wr((m_cur + 2) * 32 + 20, hexc(item_nib(m_cur)));
      end
    end
    m_prev = w;
    frame(1'b1, w);
    check_cfg("press");
  endtask

  localparam logic [15:0] B_DU = 16'h0010, B_DD = 16'h0020, B_DL = 16'h0040,
                          B_DR = 16'h0080, B_MENU = 16'h0C80;

  initial begin
    rst = 1'b1; sync_in = 2'b00; ctrl = '0;
    jumper = 8'h7F; info_set = 8'h0A; fw = 12'h2A3; m_info = 4'd5;
    load_defaults();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_wrctrl", wrctrl, 2'b00);
    check_val("rst_wraddr", wraddr, 10'd0);
    check_val("rst_wrdata", wrdata, 13'd0);
    check_val("rst_cfg0", cfg0, exp_cfg0());
    check_val("rst_cfg1", cfg1, 32'h2001_2001);
    @(posedge clk); #1 rst = 1'b0;
    drain();
    check_cfg("init");

    // Menu toggle fires once per held combination
    press(B_MENU);
    press(B_MENU);
    press(16'h0);

    // Cursor down nine times, saturating at the last item
    for (int i = 0; i < 9; i++) begin
      press(B_DD);
      press(16'h0);
    end
    for (int i = 0; i < 7; i++) begin
      press(B_DU);
      press(16'h0);
    end

    // Gamma right four times saturates at 8
    for (int i = 0; i < 4; i++) begin
      press(B_DR);
      press(16'h0);
    end

    // Du wins over Dd and Dr in the same frame
    press(B_DU | B_DD | B_DR);
    press(16'h0);
    press(B_DD);
    press(16'h0);
    press(B_DL);
    press(16'h0);
    press(B_DL);
    press(16'h0);
    for (int i = 2; i < 8; i++) begin
      press(B_DD);
      press(16'h0);
      press(B_DR);
      press(16'h0);
    end

    // Toggle beats Dd; then OSD off ignores Du; flagless tick ignored
    press(B_MENU | B_DD);
    press(16'h0);
    press(B_DU);
    press(16'h0);
    frame(1'b0, B_MENU);
    check_cfg("noflag");

    // InfoSet change rewrites its digit
    m_info = 4'd9;
    push_wr(4, hexc(m_info));
    info_set = 8'h12;
    drain();

    press(B_MENU);
    press(16'h0);
    press(B_DU);
    press(16'h0);
    press(B_DR);
    press(16'h0);

    // Fallback rising edge restores defaults and restarts the init sequence
    load_defaults();
    info_set = 8'h13;
    drain();
    check_cfg("reload");
    info_set = 8'h12;
    repeat (4) @(posedge clk);
    press(B_MENU);
    press(16'h0);
    press(B_DD);
    press(16'h0);

    check_val("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
